debounce_sync: RTL and testbench
================================

Name: debounce_sync

Overview:
- Upstream conditioning stage for the edge-detector path. Takes a raw, asynchronous, bouncing mechanical switch/button input.
- Synchronises it into the clock domain and filters contact bounce with a stability counter.
- Produces a clean level, `db_level`, intended to drive the `lvl` input of the edge detector.
- Also provides its own registered one-cycle rising-edge pulse for consumers that want it directly.

Parameters:
- `STABLE`, default 500000: consecutive-sample stability requirement (≈10 ms at 50 MHz). Legal range ≥2; benches use 4.
- `CW`, default `$clog2(STABLE)`: counter width. Must hold `STABLE-1`.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sw`  input  1  raw switch input; asynchronous to `clk`, may bounce.
- `db_level`  output  1  debounced, synchronised level; registered.
- `db_tick`  output  1  one-cycle pulse on each 0→1 transition of `db_level`; registered.

Behaviour:
- Reset: while `rst_n`=0, all flops clear asynchronously.
  - Sync flops `s1`, `s2` = 0; state = ZERO; counter = 0; `db_level`=0; `db_tick`=0.
  - Release is assumed synchronous to `clk` externally.
- Synchroniser: two-flop chain, `s1` <= `sw`, `s2` <= `s1`. Only `s2` feeds the FSM; raw `sw` is never used combinationally.
- FSM, 4 states, 2-bit encoding:
  - ZERO: `db_level`=0. If `s2`=1 → WAIT1, cnt <= `STABLE-1`.
  - WAIT1: `db_level`=0.
    - If `s2`=0 → ZERO.
    - Else if cnt==0 → ONE.
    - Else cnt <= cnt-1.
  - ONE: `db_level`=1. If `s2`=0 → WAIT0, cnt <= `STABLE-1`.
  - WAIT0: `db_level`=1.
    - If `s2`=1 → ONE.
    - Else if cnt==0 → ZERO.
    - Else cnt <= cnt-1.
  - Illegal/unused encoding → ZERO.
- Precedence: the `s2` abort check in WAIT1/WAIT0 beats counter expiry. A bounce in the same cycle as expiry aborts, and the counter restarts from full on the next entry.
- `db_level` is registered alongside the state; it is high exactly in ONE and WAIT0. The level never changes inside a WAIT state.
- `db_tick` is a registered pulse that goes high on the same edge the state enters ONE from WAIT1, and stays high for exactly one cycle.
  - WAIT0→ONE (aborted release) produces no tick.
- Acceptance window: a transition is accepted only if `sw` is sampled at the new value on `STABLE+1` consecutive rising edges.
  - Let E0 be the first such edge. `db_level` and `db_tick` change after edge E(`STABLE`+2); latency is 2 sync cycles + `STABLE` filter cycles.
  - A run of ≤`STABLE` samples is rejected with no output change.
- Falling path: symmetric, with the same latency; no tick is generated.
- Counter: unsigned, `CW` bits. It only decrements in WAIT states and never wraps, because decrement stops at 0.
- Reset mid-WAIT: all progress is discarded. After release, a full `STABLE+1` window is required again.
- `sw` held high through reset: this is treated as a fresh rising transition after release and produces `db_tick`.

Test Plan:
- `STABLE`=4, reset, then `sw` 0→1 held → `db_level`=0 through E5, `db_level`=1 from E6; `db_tick`=1 for exactly the E6–E7 cycle, 0 otherwise.
- `sw` high for 4 edges (E0..E3) then low → state returns to ZERO; `db_level` and `db_tick` stay 0 throughout.
- Bounce `sw` = 1,0,1,1,0,1 then hold 1 → no output change during the bounce; `db_level` rises 6 edges after the final 0→1 sample, with one `db_tick`.
- From ONE, `sw` goes low for 3 edges then returns high → `db_level` stays 1 and no `db_tick`. `sw` then held low → `db_level` falls 6 edges after the first low sample, with no tick.
- Deassert `rst_n` mid-WAIT1 (cnt=2) → outputs 0 immediately, asynchronously. After release with `sw` held 1 → `db_level` rises 6 edges after release, with one tick.
- Abort/expiry collision: in WAIT1, `s2` drops exactly on the cnt==0 edge → next state ZERO; no `db_level` or `db_tick` assertion.

Source files
------------

// File: rtl/debounce_sync_if.sv
// debounce_sync_if
//   Groups the switch-side signals of the debouncer.
//   sw       : raw switch input, asynchronous to the consumer clock, may bounce
//   db_level : debounced, synchronised level
//   db_tick  : one-cycle pulse on each 0->1 transition of db_level
//   master   : switch/consumer side (drives sw, observes outputs)
//   slave    : debouncer side (observes sw, drives outputs)
interface debounce_sync_if;
  logic sw;
  logic db_level;
  logic db_tick;

  modport master (
    output sw,
    input  db_level,
    input  db_tick
  );

  modport slave (
    input  sw,
    output db_level,
    output db_tick
  );
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync
//   Synchronises a raw mechanical switch input into the clk domain and
//   filters contact bounce. A new level is accepted only after the
//   synchronised input has held it for STABLE+1 consecutive samples.
//   Ports:
//     clk      : system clock, all state updates on rising edge
//     rst_n    : asynchronous active-low reset
//     bus      : debounce_sync_if.slave (sw in; db_level, db_tick out)
//   Parameters:
//     STABLE   : stability requirement in samples (>= 2)
//     CW       : counter width, must hold STABLE-1
module debounce_sync #(
  parameter int unsigned STABLE = 500000,
  parameter int unsigned CW     = $clog2(STABLE)
) (
  input  logic            clk,
  input  logic            rst_n,
  debounce_sync_if.slave  bus
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b11,
    WAIT0 = 2'b10
  } state_t;

  localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE - 1);

  logic          r_s1;
  logic          r_s2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_tick;

  state_t        w_next_state;
  logic [CW-1:0] w_next_cnt;
  logic          w_next_level;
  logic          w_next_tick;

  // Two-flop synchroniser; only r_s2 is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= bus.sw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ZERO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_level <= w_next_level;
      r_tick  <= w_next_tick;
    end
  end

  // In the WAIT states the abort check on r_s2 is tested before counter
  // expiry, so a bounce landing on the expiry cycle still aborts.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_tick  = 1'b0;
    case (r_state)
      ZERO: begin
        if (r_s2) begin
          w_next_state = WAIT1;
          w_next_cnt   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!r_s2) begin
          w_next_state = ZERO;
        end else if (r_cnt == '0) begin
          w_next_state = ONE;
          w_next_tick  = 1'b1;
        end else begin
          w_next_cnt = r_cnt - CW'(1);
        end
      end
      ONE: begin
        if (!r_s2) begin
          w_next_state = WAIT0;
          w_next_cnt   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (r_s2) begin
          w_next_state = ONE;
        end else if (r_cnt == '0) begin
          w_next_state = ZERO;
        end else begin
          w_next_cnt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_next_state = ZERO;
      end
    endcase
    // Level is registered alongside the state: high in ONE and WAIT0 only.
    w_next_level = (w_next_state == ONE) || (w_next_state == WAIT0);
  end

  assign bus.db_level = r_level;
  assign bus.db_tick  = r_tick;

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync
//   Directed bench for debounce_sync with STABLE=4. A run-length model of
//   the acceptance rule is compared against the DUT on every falling edge;
//   hand-computed per-cycle expectations pin the model in each scenario.
module tb_debounce_sync;
  localparam int STABLE = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debounce_sync_if u_if();

  debounce_sync #(.STABLE(STABLE)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int n_cmp  = 0;
  int n_bad  = 0;
  bit chk_en = 1'b0;

  // Model: sw delayed by two samples; a level flips once the delayed value
  // has differed from the current level for STABLE+1 consecutive samples.
  logic m_hist [2];
  logic m_d;
  logic m_level;
  logic m_tick;
  int   m_run;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic v);
    u_if.sw = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_hist[0] = 1'b0;
    m_hist[1] = 1'b0;
    m_level   = 1'b0;
    m_tick    = 1'b0;
    m_run     = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_hist[0] = 1'b0;
        m_hist[1] = 1'b0;
        m_level   = 1'b0;
        m_tick    = 1'b0;
        m_run     = 0;
      end else begin
        m_d       = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = u_if.sw;
        m_tick    = 1'b0;
        if (m_d !== m_level) begin
          m_run++;
          if (m_run == STABLE + 1) begin
            m_level = ~m_level;
            m_tick  = m_level;
            m_run   = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_level", u_if.db_level, m_level);
        check("model_tick",  u_if.db_tick,  m_tick);
      end
    end
  end

  logic [5:0] bpat;

  initial begin
    u_if.sw = 1'b0;
    rst_n   = 1'b0;
    bpat    = 6'b101101;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_level", u_if.db_level, 1'b0);
    check("reset_tick",  u_if.db_tick,  1'b0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0);

    // Clean rise: level from E6, tick only on E6.
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1);
      check("rise_level", u_if.db_level, k >= 6);
      check("rise_tick",  u_if.db_tick,  k == 6);
    end
    repeat (2) cyc(1'b1);

    // Low for 3 samples from ONE: release aborted, no output change.
    for (int k = 0; k < 7; k++) begin
      cyc((k < 3) ? 1'b0 : 1'b1);
      check("abort0_level", u_if.db_level, 1'b1);
      check("abort0_tick",  u_if.db_tick,  1'b0);
    end

    // Held low: level falls after E6, never a tick.
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0);
      check("fall_level", u_if.db_level, k < 6);
      check("fall_tick",  u_if.db_tick,  1'b0);
    end

    // High for only STABLE samples: abort lands on the expiry cycle.
    for (int k = 0; k < 12; k++) begin
      cyc((k < 4) ? 1'b1 : 1'b0);
      check("short_level", u_if.db_level, 1'b0);
      check("short_tick",  u_if.db_tick,  1'b0);
    end

    // Bounce 1,0,1,1,0,1 then hold: rise 6 edges after the final 0->1 sample.
    for (int j = 0; j < 16; j++) begin
      cyc((j < 6) ? bpat[5-j] : 1'b1);
      check("bounce_level", u_if.db_level, j >= 11);
      check("bounce_tick",  u_if.db_tick,  j == 11);
    end

    // Asynchronous reset from ONE clears the level before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_level", u_if.db_level, 1'b0);
    check("async_rst_tick",  u_if.db_tick,  1'b0);
    repeat (2) cyc(1'b0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0);

    // Reset in WAIT1 with cnt=2, sw held high through and after reset.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1);
      check("pre_rst_level", u_if.db_level, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("wait_rst_level", u_if.db_level, 1'b0);
    check("wait_rst_tick",  u_if.db_tick,  1'b0);
    repeat (2) cyc(1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1);
      check("post_rst_level", u_if.db_level, k >= 6);
      check("post_rst_tick",  u_if.db_tick,  k == 6);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
